// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined bitwise logic unit with per-issue op select,
// reservation-station tag carry, valid/ready flow control and flush.
module logic_unit_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             busy
);

  localparam int unsigned LAST = STAGES - 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [STAGES-1:0] ready;
  logic [WIDTH-1:0]  result;

  // Bitwise operation selected per issue
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = in1 & in2;
      OP_OR:   result = in1 | in2;
      OP_XOR:  result = in1 ^ in2;
      OP_XNOR: result = ~(in1 ^ in2);
      OP_NAND: result = ~(in1 & in2);
      OP_NOR:  result = ~(in1 | in2);
      OP_NOT:  result = ~in1;
      OP_PASS: result = in1;
      default: result = '0;
    endcase
  end

  // Backward ready chain: a stage can load if it is empty or the one ahead can move
  always_comb begin
    logic chain;
    chain = out_ready;
    ready = '0;
    for (int i = int'(LAST); i >= 0; i--) begin
      chain    = chain | ~v_q[i];
      ready[i] = chain;
    end
  end

  // Pipeline registers; flush only clears valid bits, payload may go stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      if (ready[0]) begin
        v_q[0]    <= in_valid;
        data_q[0] <= result;
        tag_q[0]  <= in_tag;
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        if (ready[i]) begin
          v_q[i]    <= v_q[i-1];
          data_q[i] <= data_q[i-1];
          tag_q[i]  <= tag_q[i-1];
        end
      end
      if (flush) begin
        v_q <= '0;
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = v_q[LAST];
  assign out       = data_q[LAST];
  assign out_tag   = tag_q[LAST];
  assign out_zero  = (data_q[LAST] == '0);
  assign busy      = |v_q;

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Pipelined, parameterised logic functional unit for the Tomasulo execution cluster. It takes over from the fixed 32-bit bitwise gate arrays, whose operation is selected by which array is wired in. This block instead selects any of eight bitwise operations per issue and carries the issuing reservation-station tag alongside the data. It accepts one operation per cycle through a valid/ready handshake. Results are held until the common data bus (CDB) arbiter grants them. It supports a synchronous flush for mispredict or exception recovery.

## Interface
- WIDTH, 32, operand and result width in bits (≥1)
- TAG_W, 4, reservation-station tag width (≥1)
- STAGES, 2, pipeline depth in register stages (≥1)

- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  issue request
- IN_READY  out  1  unit can accept an issue this cycle
- OP  in  3  operation select
- IN1  in  WIDTH  operand A
- IN2  in  WIDTH  operand B
- IN_TAG  in  TAG_W  tag of the issuing reservation station
- FLUSH  in  1  synchronous kill of every in-flight operation
- OUT_VALID  out  1  result present at the last stage
- OUT_READY  in  1  CDB grant; the result is consumed when OUT_VALID && OUT_READY
- OUT  out  WIDTH  result
- OUT_TAG  out  TAG_W  tag of the result
- OUT_ZERO  out  1  high when OUT == 0
- BUSY  out  1  high when any stage is valid

## Operation
- OP encoding:
  - 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR
  - 110 NOT IN1 (IN2 ignored), 111 PASS IN1
- The result is computed combinationally from IN1, IN2 and OP, then registered into stage 1 together with IN_TAG. Stages 2..STAGES carry data and tag unchanged.
- Each stage i holds a valid bit v[i].
  - ready[STAGES] = !v[STAGES] | OUT_READY
  - ready[i] = !v[i] | ready[i+1]
  - IN_READY = ready[1]
- Stage i loads from stage i-1 (or from the input, for i = 1) when ready[i] is high. Otherwise it holds its data, tag and valid bit.
- Issue is accepted when IN_VALID && IN_READY. If IN_VALID is high while IN_READY is low, nothing is captured; the issuer must hold its request.
- OUT, OUT_TAG and OUT_VALID come directly from the last-stage registers and are stable while OUT_VALID && !OUT_READY.
- OUT_ZERO is decoded combinationally from the last-stage data register.
- FLUSH:
  - Clears every valid bit on the next edge.
  - An issue presented in the same cycle is discarded, even if IN_READY is high.
  - A result handshaking on the same cycle counts as consumed; the CDB sampling it is legal.
  - Data and tag registers may keep stale values.
- BUSY = OR of all v[i].

## Timing
- Reset (RST_N low, asynchronous): all v[i] = 0, all data and tag registers = 0. Outputs are then OUT_VALID 0, OUT 0, OUT_TAG 0, OUT_ZERO 1, BUSY 0, IN_READY 1.
- Latency: an issue accepted at edge N appears with OUT_VALID = 1 after edge N+STAGES-1, i.e. STAGES cycles of pipeline, provided there are no stalls.
- Throughput: one op per cycle while OUT_READY stays high.
- Full pipeline with OUT_READY low:
  - IN_READY falls combinationally.
  - Exactly STAGES ops are held, with no loss and no duplication.
  - Raising OUT_READY releases one op per cycle, in issue order.
- Bubbles collapse: an empty stage always accepts from the stage behind it, even while the output is stalled.
- A reset assertion mid-operation drops all in-flight ops. No result is emitted after RST_N is released until a new issue.

## Test plan
- Reset, then OUT_READY = 1. Issue one op each cycle with WIDTH = 32, IN1 = 0xF0F0_1234, IN2 = 0x0FF0_FFFF, OP = 000..111, tags 0..7. Required results appear in tag order STAGES cycles later:
  - 0x00F0_1234, 0xFFF0_FFFF, 0xFF00_EDCB, 0x00FF_1234
  - 0xFF0F_EDCB, 0x000F_0000, 0x0F0F_EDCB, 0xF0F0_1234
- OUT_READY = 0, issue 4 ops with STAGES = 2: ops 1–2 accepted, IN_READY low from the cycle after the second acceptance, OUT_TAG of op 1 held stable. Raise OUT_READY: ops 1 and 2 emerge on consecutive cycles, then ops 3 and 4 are accepted.
- Issue XOR of IN1 = IN2 = 0xDEAD_BEEF, tag 5 -> OUT = 0, OUT_ZERO = 1, OUT_TAG = 5.
- Fill the pipeline with OUT_READY = 0, then assert FLUSH together with IN_VALID. Next cycle: OUT_VALID = 0, BUSY = 0; the same-cycle issue never appears at the output.
- Pull RST_N low asynchronously, mid-clock, with 2 ops in flight. Immediately: OUT_VALID = 0, OUT = 0. After release: no output until a fresh issue, which returns after STAGES cycles.
- Run with STAGES = 1, WIDTH = 8: back-to-back NAND of 0xAA and 0x0F -> 0xF5 one cycle later, at full throughput.
